// File: rtl/ps2_key_sequencer_pkg.sv
// Shared PS/2 scan-code constants and sequencer state encoding.
// Imported by the key sequencer and by anything that decodes its event stream.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT  = 8'hE0;
   localparam logic [7:0] PS2_BRK  = 8'hF0;
   localparam logic [7:0] PS2_ERR0 = 8'h00;
   localparam logic [7:0] PS2_ERR1 = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_POP   = 2'd1,
      ST_GUARD = 2'd2,
      ST_EMIT  = 2'd3
   } state_e;

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// Bundle of the receiver-FIFO side and the key-event side of the sequencer.
// master = surrounding system (receiver + event consumer); slave = sequencer.
interface ps2_key_sequencer_if;

   // Receiver side: rx_data is valid whenever rx_ready=1; the sequencer pops it
   // with a one-cycle low pulse on rx_nextdata_n.
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_overflow;
   logic       rx_nextdata_n;

   // Event side: an event transfers on a cycle with ev_valid=1 and ev_ready=1;
   // while ev_valid=1 and ev_ready=0 the ev_* fields hold steady, and ev_valid
   // never drops without a transfer.
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;

   modport master (
      output rx_ready, rx_data, rx_overflow, ev_ready,
      input  rx_nextdata_n, ev_valid, ev_code, ev_ext, ev_break
   );

   modport slave (
      input  rx_ready, rx_data, rx_overflow, ev_ready,
      output rx_nextdata_n, ev_valid, ev_code, ev_ext, ev_break
   );

endinterface

// File: rtl/ps2_key_sequencer.sv
// Turns raw PS/2 scan-code bytes into make/break key events with prefixes
// folded in, tracks the held key and counts key presses.
module ps2_key_sequencer
   import ps2_pkg::*;
#(
   parameter bit TYPEMATIC_FILTER = 1'b1
) (
   input  logic                 clk,
   input  logic                 clrn,
   ps2_key_sequencer_if.slave   bus,
   output logic [7:0]           press_cnt,
   output logic                 held,
   output logic [8:0]           held_code,
   output logic                 ovf_sticky,
   output state_e               dbg_state
);

   state_e     state_q, state_d;
   logic [7:0] byte_q, byte_d;
   logic       ext_q, ext_d;
   logic       brk_q, brk_d;
   logic [7:0] ev_code_q, ev_code_d;
   logic       ev_ext_q, ev_ext_d;
   logic       ev_brk_q, ev_brk_d;
   logic [7:0] press_q, press_d;
   logic       held_q, held_d;
   logic [8:0] held_code_q, held_code_d;
   logic       ovf_q, ovf_d;
   logic       emit;
   logic [8:0] key;

   assign key = {ext_q, byte_q};

   // State register
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         byte_q      <= '0;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         ev_code_q   <= '0;
         ev_ext_q    <= 1'b0;
         ev_brk_q    <= 1'b0;
         press_q     <= '0;
         held_q      <= 1'b0;
         held_code_q <= '0;
         ovf_q       <= 1'b0;
      end else begin
         byte_q      <= byte_d;
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         ev_code_q   <= ev_code_d;
         ev_ext_q    <= ev_ext_d;
         ev_brk_q    <= ev_brk_d;
         press_q     <= press_d;
         held_q      <= held_d;
         held_code_q <= held_code_d;
         ovf_q       <= ovf_d;
      end
   end

   // Byte decode: acts only in GUARD, on the byte latched when leaving IDLE.
   always_comb begin
      byte_d      = byte_q;
      ext_d       = ext_q;
      brk_d       = brk_q;
      ev_code_d   = ev_code_q;
      ev_ext_d    = ev_ext_q;
      ev_brk_d    = ev_brk_q;
      press_d     = press_q;
      held_d      = held_q;
      held_code_d = held_code_q;
      ovf_d       = ovf_q;
      emit        = 1'b0;

      if (state_q == ST_IDLE && bus.rx_ready) byte_d = bus.rx_data;

      if (state_q == ST_GUARD) begin
         case (byte_q)
            PS2_EXT: ext_d = 1'b1;
            PS2_BRK: brk_d = 1'b1;
            PS2_ERR0, PS2_ERR1: begin
               ext_d = 1'b0;
               brk_d = 1'b0;
            end
            default: begin
               ext_d = 1'b0;
               brk_d = 1'b0;
               if (brk_q) begin
                  emit = 1'b1;
                  if (held_q && key == held_code_q) held_d = 1'b0;
               end else if (!(TYPEMATIC_FILTER && held_q && key == held_code_q)) begin
                  emit        = 1'b1;
                  held_d      = 1'b1;
                  held_code_d = key;
                  press_d     = press_q + 8'd1;
               end
               if (emit) begin
                  ev_code_d = byte_q;
                  ev_ext_d  = ext_q;
                  ev_brk_d  = brk_q;
               end
            end
         endcase
      end

      // An overflow means bytes were lost, so any half-seen prefix is untrusted.
      if (bus.rx_overflow) begin
         ovf_d = 1'b1;
         ext_d = 1'b0;
         brk_d = 1'b0;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.rx_ready) state_d = ST_POP;
         ST_POP:   state_d = ST_GUARD;
         ST_GUARD: state_d = emit ? ST_EMIT : ST_IDLE;
         ST_EMIT:  if (bus.ev_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.rx_nextdata_n = (state_q != ST_POP);
      bus.ev_valid      = (state_q == ST_EMIT);
   end

   assign bus.ev_code  = ev_code_q;
   assign bus.ev_ext   = ev_ext_q;
   assign bus.ev_break = ev_brk_q;
   assign press_cnt    = press_q;
   assign held         = held_q;
   assign held_code    = held_code_q;
   assign ovf_sticky   = ovf_q;
   assign dbg_state    = state_q;

endmodule
